// File: rtl/param_sync_fifo_pkg.sv
// Shared helpers for param_sync_fifo: address-width calculation and
// elaboration-time parameter legality checks.
package param_sync_fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // almost_full must be reachable and must not be on permanently from reset
  function automatic bit af_thresh_legal(input int af_thresh, input int depth);
    return (af_thresh >= 1) && (af_thresh <= depth);
  endfunction

  function automatic bit ae_thresh_legal(input int ae_thresh, input int depth);
    return (ae_thresh >= 0) && (ae_thresh < depth);
  endfunction

endpackage

// File: rtl/param_sync_fifo_ram.sv
// Storage array for param_sync_fifo: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_ram
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  localparam int ADDR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags and optional FWFT read mode.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 5,
  parameter int AF_THRESH  = (1 << DEPTH_LOG2) - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  read,
  output logic [DATA_W-1:0]     data_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  if (!af_thresh_legal(AF_THRESH, DEPTH)) begin : g_bad_af_thresh
    $error("param_sync_fifo: AF_THRESH=%0d outside 1..%0d", AF_THRESH, DEPTH);
  end
  if (!ae_thresh_legal(AE_THRESH, DEPTH)) begin : g_bad_ae_thresh
    $error("param_sync_fifo: AE_THRESH=%0d outside 0..%0d", AE_THRESH, DEPTH - 1);
  end

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] ram_rd_data;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rd_data (ram_rd_data)
  );

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A read on a full FIFO frees the slot the simultaneous write needs
  assign rd_acc = read && !fifo_empty;
  assign wr_acc = write && (!fifo_full || rd_acc);

  assign data_out = FWFT ? (fifo_empty ? '0 : ram_rd_data) : dout_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      dout_d   = ram_rd_data;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    // Error events take priority over a clear on the same edge
    if (clear_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (write && !wr_acc) begin
      overflow_d = 1'b1;
    end
    if (read && fifo_empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: a standard-mode and an FWFT-mode FIFO share one
// stimulus stream and are compared each cycle against a queue-based model.
module tb_param_sync_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int AF     = 30;
  localparam int AE     = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              write = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              read = 1'b0;
  logic              clear_err = 1'b0;

  logic [DATA_W-1:0] std_data_out, fwft_data_out;
  logic              std_empty, std_full, std_af, std_ae, std_ovf, std_udf;
  logic              fwft_empty, fwft_full, fwft_af, fwft_ae, fwft_ovf, fwft_udf;
  logic [5:0]        std_count, fwft_count;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] model_std_out = '0;
  logic              model_ovf = 1'b0;
  logic              model_udf = 1'b0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(5), .AF_THRESH(AF),
                    .AE_THRESH(AE), .FWFT(1'b0)) u_std (
    .clk(clk), .reset(reset), .write(write), .data_in(data_in), .read(read),
    .data_out(std_data_out), .fifo_empty(std_empty), .fifo_full(std_full),
    .almost_full(std_af), .almost_empty(std_ae), .fifo_count(std_count),
    .overflow(std_ovf), .underflow(std_udf), .clear_err(clear_err));

  param_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(5), .AF_THRESH(AF),
                    .AE_THRESH(AE), .FWFT(1'b1)) u_fwft (
    .clk(clk), .reset(reset), .write(write), .data_in(data_in), .read(read),
    .data_out(fwft_data_out), .fifo_empty(fwft_empty), .fifo_full(fwft_full),
    .almost_full(fwft_af), .almost_empty(fwft_ae), .fifo_count(fwft_count),
    .overflow(fwft_ovf), .underflow(fwft_udf), .clear_err(clear_err));

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model advances on each edge from the sampled inputs, then the outputs of
  // both instances are compared once they have settled.
  always @(posedge clk) begin
    bit m_full, m_empty, m_racc, m_wacc;
    if (reset) begin
      model_q.delete();
      model_std_out = '0;
      model_ovf     = 1'b0;
      model_udf     = 1'b0;
    end else begin
      m_full  = (model_q.size() == DEPTH);
      m_empty = (model_q.size() == 0);
      m_racc  = read && !m_empty;
      m_wacc  = write && (!m_full || m_racc);
      if (clear_err) begin
        model_ovf = 1'b0;
        model_udf = 1'b0;
      end
      if (write && !m_wacc) model_ovf = 1'b1;
      if (read && m_empty) model_udf = 1'b1;
      if (m_racc) model_std_out = model_q.pop_front();
      if (m_wacc) model_q.push_back(data_in);
    end
    #1;
    if (check_en) begin
      int n;
      n = model_q.size();
      check_output("std_count", 32'(std_count), 32'(n));
      check_output("fwft_count", 32'(fwft_count), 32'(n));
      check_output("std_empty", 32'(std_empty), 32'(n == 0));
      check_output("fwft_empty", 32'(fwft_empty), 32'(n == 0));
      check_output("std_full", 32'(std_full), 32'(n == DEPTH));
      check_output("fwft_full", 32'(fwft_full), 32'(n == DEPTH));
      check_output("std_af", 32'(std_af), 32'(n >= AF));
      check_output("fwft_af", 32'(fwft_af), 32'(n >= AF));
      check_output("std_ae", 32'(std_ae), 32'(n <= AE));
      check_output("fwft_ae", 32'(fwft_ae), 32'(n <= AE));
      check_output("std_ovf", 32'(std_ovf), 32'(model_ovf));
      check_output("fwft_ovf", 32'(fwft_ovf), 32'(model_ovf));
      check_output("std_udf", 32'(std_udf), 32'(model_udf));
      check_output("fwft_udf", 32'(fwft_udf), 32'(model_udf));
      check_output("std_data", 32'(std_data_out), 32'(model_std_out));
      check_output("fwft_data", 32'(fwft_data_out), (n == 0) ? 32'd0 : 32'(model_q[0]));
    end
  end

  // Drive inputs on the falling edge; return after the following rising
  // edge has been compared so literal checks see settled outputs.
  task automatic apply_stimulus(input logic w, input logic [DATA_W-1:0] d,
                                input logic r, input logic c);
    @(negedge clk);
    write     = w;
    data_in   = d;
    read      = r;
    clear_err = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    check_en = 1'b1;
    repeat (2) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("rst_empty", 32'(std_empty), 32'd1);
    check_output("rst_full", 32'(std_full), 32'd0);
    check_output("rst_count", 32'(std_count), 32'd0);
    check_output("rst_data", 32'(std_data_out), 32'd0);
    check_output("rst_ae", 32'(std_ae), 32'd1);

    // Fill past capacity: words 32..39 must be dropped
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b1, DATA_W'(i), 1'b0, 1'b0);
      if (i == 28) check_output("af_at_29", 32'(std_af), 32'd0);
      if (i == 29) check_output("af_at_30", 32'(std_af), 32'd1);
      if (i == 30) check_output("full_at_31", 32'(std_full), 32'd0);
      if (i == 31) check_output("full_at_32", 32'(std_full), 32'd1);
    end
    check_output("fill_count", 32'(std_count), 32'd32);
    check_output("fill_ovf", 32'(std_ovf), 32'd1);

    // Drain plus one extra read
    for (int i = 0; i < 33; i++) begin
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      if (i < 32) check_output("drain_data", 32'(std_data_out), 32'(i));
    end
    check_output("drain_udf", 32'(std_udf), 32'd1);
    check_output("drain_hold", 32'(std_data_out), 32'd31);

    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check_output("clr_ovf", 32'(std_ovf), 32'd0);
    check_output("clr_udf", 32'(std_udf), 32'd0);

    // Simultaneous write and read while full
    for (int i = 0; i < 32; i++) apply_stimulus(1'b1, DATA_W'(200 + i), 1'b0, 1'b0);
    apply_stimulus(1'b1, DATA_W'(100), 1'b1, 1'b0);
    check_output("simul_count", 32'(std_count), 32'd32);
    check_output("simul_full", 32'(std_full), 32'd1);
    check_output("simul_ovf", 32'(std_ovf), 32'd0);
    check_output("simul_data", 32'(std_data_out), 32'd200);
    for (int i = 0; i < 32; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("simul_last", 32'(std_data_out), 32'd100);

    // Three rounds of 20 across the pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) apply_stimulus(1'b1, DATA_W'(1000 + r * 20 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    end
    check_output("wrap_count", 32'(std_count), 32'd0);
    check_output("wrap_last", 32'(std_data_out), 32'd1059);

    // Fall-through visibility and pop
    apply_stimulus(1'b1, 16'hABCD, 1'b0, 1'b0);
    check_output("fwft_show", 32'(fwft_data_out), 32'h0000ABCD);
    check_output("fwft_nonempty", 32'(fwft_empty), 32'd0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    check_output("fwft_pop_empty", 32'(fwft_empty), 32'd1);
    check_output("std_pop_data", 32'(std_data_out), 32'h0000ABCD);

    // Underflow set wins over a simultaneous clear, then clears alone
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    check_output("set_wins", 32'(fwft_udf), 32'd1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check_output("clr_alone", 32'(fwft_udf), 32'd0);

    // Empty + write + read: write accepted, read rejected
    apply_stimulus(1'b1, 16'h0055, 1'b1, 1'b0);
    check_output("ewr_count", 32'(std_count), 32'd1);
    check_output("ewr_udf", 32'(std_udf), 32'd1);

    // Reset mid-operation discards stored data
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, DATA_W'(i + 7), 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("mid_rst_count", 32'(std_count), 32'd0);
    check_output("mid_rst_empty", 32'(fwft_empty), 32'd1);
    check_output("mid_rst_data", 32'(std_data_out), 32'd0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO, next generation of the team's 16x32 synchronous FIFO. Adds configurable width/depth, a correctly sized occupancy count (0..DEPTH inclusive), programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. Used as the generic buffering element between streaming blocks in one clock domain.

## Interface
- DATA_W, 16, data word width in bits (>=1)
- DEPTH_LOG2, 5, log2 of entry count; DEPTH = 1<<DEPTH_LOG2 (>=1)
- AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- write  in  1  write request
- data_in  in  DATA_W  write data
- read  in  1  read request
- data_out  out  DATA_W  read data
- fifo_empty  out  1  count == 0
- fifo_full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- fifo_count  out  DEPTH_LOG2+1  current occupancy
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty
- clear_err  in  1  clears overflow/underflow

## Operation
- Pointers wr_ptr/rd_ptr are DEPTH_LOG2+1 bits (extra wrap bit); address = low DEPTH_LOG2 bits, wrap naturally at DEPTH.
- rd_acc = read && !fifo_empty. wr_acc = write && (!fifo_full || rd_acc).
- Full + write + read: both accepted, count unchanged, wr_ptr and rd_ptr both advance.
- Empty + write + read: read rejected (underflow set), write accepted, count -> 1.
- Full + write, no read: write dropped, wr_ptr and memory stable, fifo_full stays 1, overflow set.
- count update: +1 on wr_acc only, -1 on rd_acc only, else hold; never exceeds DEPTH or goes below 0.
- Flags are combinational decodes of registered count/pointers only (no path from write/read inputs).
- Standard mode (FWFT=0): data_out register loads mem[rd_addr] on rd_acc, otherwise holds.
- FWFT mode: data_out = mem[rd_addr] whenever !fifo_empty; read pops the shown word; data_out is don't-care when empty (driven 0).
- overflow/underflow: set on the error event, cleared by clear_err; set wins over clear on the same edge.
- Reset: pointers, count = 0; fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0 (unless AF_THRESH==0, disallowed), overflow=underflow=0, data_out=0. Memory contents not reset. Reset mid-operation discards all stored data.

## Timing
- Write accepted at edge N: fifo_count/flags reflect it after edge N.
- Standard read: rd_acc at edge N -> data valid on data_out after edge N (1-cycle latency), held until next rd_acc.
- FWFT: first word written at edge N visible on data_out after edge N (same time fifo_empty falls).
- Write and read of same location in one cycle cannot occur except on full (read sees old data, correct).
- Error flags assert after the offending edge.

## Structure
- Package param_sync_fifo_pkg: clog2 helper, parameter-legality checks as constant functions (AF_THRESH in 1..DEPTH, AE_THRESH < DEPTH).
- Sub-module fifo_ram: DEPTH x DATA_W, one synchronous write port, one asynchronous read port; top holds pointers, count, flags, errors, read register.
- Elaboration-time $error on illegal parameters.

## Test plan
- Reset check: after reset with write=read=0 -> fifo_empty=1, fifo_full=0, fifo_count=0, data_out=0, almost_empty=1.
- Fill (DEPTH_LOG2=5): write 0..39 consecutively -> count reaches 32, fifo_full=1 at 32nd write, almost_full at count 30, words 32..39 dropped, wr_ptr stable, overflow=1.
- Drain standard mode: read 33 times from full -> data_out 0..31 in order, each one cycle after accept; 33rd read sets underflow, data_out holds 31.
- Simultaneous on full: full FIFO, write=read=1 with data 100 -> count stays 32, fifo_full stays 1, data 100 later read as last word.
- Wrap-around: 3 rounds of write 20 / read 20 -> data sequence intact across pointer wrap, count returns to 0.
- FWFT=1: write 0xABCD into empty FIFO -> data_out=0xABCD after same edge fifo_empty falls; read pops it, fifo_empty=1; clear_err clears sticky flags.
